// File: rtl/olivia_mc_ctrl_if.sv
// Shared instruction/data memory port between the Olivia sequencer and memory.
// The sequencer holds mem_req/mem_we/mem_addr_sel stable until mem_ack.
interface olivia_mc_ctrl_if;
   logic mem_req;
   logic mem_we;
   logic mem_addr_sel;
   logic mem_ack;

   modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ack);
   modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ack);
endinterface

// File: rtl/olivia_mc_ctrl.sv
// Olivia LEGv8 multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared
// memory port, driving every datapath enable and select.
module olivia_mc_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                    CLK,
   input  logic                    RST,
   olivia_mc_ctrl_if.master        mem,
   input  logic [10:0]             opcode,
   input  logic                    zero,
   output logic                    ir_we,
   output logic                    pc_we,
   output logic [1:0]              pc_src,
   output logic                    a_we,
   output logic                    reg2loc,
   output logic                    alu_src_b,
   output logic [3:0]              alu_ctl,
   output logic                    alu_out_we,
   output logic                    mdr_we,
   output logic                    reg_we,
   output logic                    mem_to_reg,
   output logic                    retired,
   output logic                    halted,
   output logic [2:0]              state
);

   localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ, OP_B, OP_NOP, OP_ILL
   } op_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          timeout_hit;
   op_t           op;
   logic          mem_req, mem_we, mem_addr_sel;

   always_comb begin
      op = OP_ILL;
      casez (opcode)
         11'b10001011000: op = OP_ADD;
         11'b11001011000: op = OP_SUB;
         11'b10001010000: op = OP_AND;
         11'b10101010000: op = OP_ORR;
         11'b11111000010: op = OP_LDUR;
         11'b11111000000: op = OP_STUR;
         11'b10110100???: op = OP_CBZ;
         11'b000101?????: op = OP_B;
         11'b00000000000: op = OP_NOP;
         default:         op = OP_ILL;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= S_RESET;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_inc      = cnt_q + 1'b1;
      cnt_d        = cnt_q;
      timeout_hit  = (TIMEOUT_CYCLES != 0) && (32'(cnt_inc) == TIMEOUT_CYCLES);
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 2'd0;
      a_we         = 1'b0;
      reg2loc      = 1'b0;
      alu_src_b    = 1'b0;
      alu_ctl      = 4'b0000;
      alu_out_we   = 1'b0;
      mdr_we       = 1'b0;
      reg_we       = 1'b0;
      mem_to_reg   = 1'b0;
      retired      = 1'b0;
      halted       = 1'b0;

      unique case (state_q)
         S_RESET: begin
            cnt_d   = '0;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem.mem_ack) begin
               cnt_d   = '0;
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end else begin
               cnt_d = cnt_inc;
               if (timeout_hit) state_d = S_HALT;
            end
         end
         S_DECODE: begin
            a_we    = 1'b1;
            reg2loc = (op == OP_STUR) || (op == OP_CBZ);
            state_d = (op == OP_ILL) ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            alu_out_we = 1'b1;
            unique case (op)
               OP_ADD: begin alu_ctl = 4'b0010; state_d = S_WB; end
               OP_SUB: begin alu_ctl = 4'b0110; state_d = S_WB; end
               OP_AND: begin alu_ctl = 4'b0000; state_d = S_WB; end
               OP_ORR: begin alu_ctl = 4'b0001; state_d = S_WB; end
               OP_LDUR, OP_STUR: begin
                  alu_ctl   = 4'b0010;
                  alu_src_b = 1'b1;
                  state_d   = S_MEM;
               end
               OP_CBZ: begin
                  alu_ctl = 4'b0111;
                  pc_we   = zero;
                  pc_src  = 2'd1;
                  retired = 1'b1;
                  state_d = S_FETCH;
               end
               OP_B: begin
                  pc_we   = 1'b1;
                  pc_src  = 2'd2;
                  retired = 1'b1;
                  state_d = S_FETCH;
               end
               OP_NOP: begin
                  retired = 1'b1;
                  state_d = S_FETCH;
               end
               default: state_d = S_HALT;
            endcase
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (op == OP_STUR);
            if (mem.mem_ack) begin
               cnt_d = '0;
               if (op == OP_STUR) begin
                  retired = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  mdr_we  = 1'b1;
                  state_d = S_WB;
               end
            end else begin
               cnt_d = cnt_inc;
               if (timeout_hit) state_d = S_HALT;
            end
         end
         S_WB: begin
            reg_we     = 1'b1;
            mem_to_reg = (op == OP_LDUR);
            retired    = 1'b1;
            state_d    = S_FETCH;
         end
         S_HALT: halted = 1'b1;
         default: state_d = S_HALT;
      endcase
   end

   assign mem.mem_req      = mem_req;
   assign mem.mem_we       = mem_we;
   assign mem.mem_addr_sel = mem_addr_sel;
   assign state            = state_q;

endmodule

// File: tb/tb_olivia_mc_ctrl.sv
// Directed bench for olivia_mc_ctrl: per-cycle expected output vectors go
// through a scoreboard queue and are compared at the falling clock edge.
module tb_olivia_mc_ctrl;

   typedef struct packed {
      logic [2:0] st;
      logic       req, we, asel, ir_we, pc_we;
      logic [1:0] pc_src;
      logic       a_we, r2l, asrc;
      logic [3:0] alu;
      logic       aowe, mdr_we, reg_we, m2r, ret, halted;
   } ov_t;

   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;
   localparam logic [10:0] OPC_CBZ  = 11'b10110100101;
   localparam logic [10:0] OPC_B    = 11'b00010111111;
   localparam logic [10:0] OPC_NOP  = 11'b00000000000;
   localparam logic [10:0] OPC_ILL  = 11'b11111111111;

   logic        CLK, RST, zero;
   logic [10:0] opcode;
   logic        ir_we, pc_we, a_we, reg2loc, alu_src_b, alu_out_we;
   logic        mdr_we, reg_we, mem_to_reg, retired, halted;
   logic [1:0]  pc_src;
   logic [3:0]  alu_ctl;
   logic [2:0]  state;

   olivia_mc_ctrl_if mem_if ();

   olivia_mc_ctrl #(.TIMEOUT_CYCLES(16)) dut (
      .CLK(CLK), .RST(RST), .mem(mem_if), .opcode(opcode), .zero(zero),
      .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .a_we(a_we),
      .reg2loc(reg2loc), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl),
      .alu_out_we(alu_out_we), .mdr_we(mdr_we), .reg_we(reg_we),
      .mem_to_reg(mem_to_reg), .retired(retired), .halted(halted), .state(state)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   ov_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;

   function automatic ov_t mk(input logic [2:0] st);
      ov_t v;
      v    = '0;
      v.st = st;
      return v;
   endfunction

   // Push the expectation for the current cycle, compare at negedge, advance.
   task automatic cyc(input string tag, input ov_t e);
      ov_t obs, exp_v;
      exp_q.push_back(e);
      @(negedge CLK);
      obs = {state, mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr_sel, ir_we, pc_we,
             pc_src, a_we, reg2loc, alu_src_b, alu_ctl, alu_out_we, mdr_we, reg_we,
             mem_to_reg, retired, halted};
      exp_v = exp_q.pop_front();
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic fetch_ack(input string tag, input logic [10:0] opc);
      ov_t e;
      opcode        = opc;
      mem_if.mem_ack = 1'b1;
      e = mk(3'd1); e.req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
      cyc(tag, e);
   endtask

   task automatic decode(input string tag, input logic r2l);
      ov_t e;
      e = mk(3'd2); e.a_we = 1'b1; e.r2l = r2l;
      cyc(tag, e);
   endtask

   task automatic rtype(input string tag, input logic [10:0] opc, input logic [3:0] alu);
      ov_t e;
      fetch_ack({tag, "_fetch"}, opc);
      decode({tag, "_decode"}, 1'b0);
      e = mk(3'd3); e.aowe = 1'b1; e.alu = alu;
      cyc({tag, "_exec"}, e);
      e = mk(3'd5); e.reg_we = 1'b1; e.ret = 1'b1;
      cyc({tag, "_wb"}, e);
   endtask

   task automatic release_reset(input string tag);
      ov_t e;
      RST = 1'b0;
      e = mk(3'd0);
      @(posedge CLK); #1;
      cyc({tag, "_reset"}, e);
      RST = 1'b1;
      cyc({tag, "_reset_last"}, e);
   endtask

   initial begin
      ov_t e;
      RST            = 1'b0;
      zero           = 1'b0;
      opcode         = OPC_NOP;
      mem_if.mem_ack = 1'b1;

      // Reset held two edges with ack tied high; first FETCH cycle after release.
      @(posedge CLK); #1;
      e = mk(3'd0);
      cyc("reset_cyc1", e);
      RST = 1'b1;
      cyc("reset_cyc2", e);

      rtype("add", OPC_ADD, 4'b0010);
      rtype("sub", OPC_SUB, 4'b0110);
      rtype("and", OPC_AND, 4'b0000);
      rtype("orr", OPC_ORR, 4'b0001);

      // FETCH with one wait cycle, then NOP.
      opcode = OPC_NOP; mem_if.mem_ack = 1'b0;
      e = mk(3'd1); e.req = 1'b1;
      cyc("fetch_wait", e);
      fetch_ack("nop_fetch", OPC_NOP);
      decode("nop_decode", 1'b0);
      e = mk(3'd3); e.aowe = 1'b1; e.ret = 1'b1;
      cyc("nop_exec", e);

      // LDUR with three MEM wait cycles.
      fetch_ack("ldur_fetch", OPC_LDUR);
      decode("ldur_decode", 1'b0);
      e = mk(3'd3); e.aowe = 1'b1; e.asrc = 1'b1; e.alu = 4'b0010;
      cyc("ldur_exec", e);
      mem_if.mem_ack = 1'b0;
      e = mk(3'd4); e.req = 1'b1; e.asel = 1'b1;
      for (int i = 0; i < 3; i++) cyc("ldur_mem_wait", e);
      mem_if.mem_ack = 1'b1;
      e.mdr_we = 1'b1;
      cyc("ldur_mem_ack", e);
      e = mk(3'd5); e.reg_we = 1'b1; e.m2r = 1'b1; e.ret = 1'b1;
      cyc("ldur_wb", e);

      // STUR, zero-wait.
      fetch_ack("stur_fetch", OPC_STUR);
      decode("stur_decode", 1'b1);
      e = mk(3'd3); e.aowe = 1'b1; e.asrc = 1'b1; e.alu = 4'b0010;
      cyc("stur_exec", e);
      e = mk(3'd4); e.req = 1'b1; e.we = 1'b1; e.asel = 1'b1; e.ret = 1'b1;
      cyc("stur_mem", e);

      // CBZ taken and not taken.
      zero = 1'b1;
      fetch_ack("cbz1_fetch", OPC_CBZ);
      decode("cbz1_decode", 1'b1);
      e = mk(3'd3); e.aowe = 1'b1; e.alu = 4'b0111; e.pc_we = 1'b1; e.pc_src = 2'd1; e.ret = 1'b1;
      cyc("cbz1_exec", e);
      zero = 1'b0;
      fetch_ack("cbz0_fetch", OPC_CBZ);
      decode("cbz0_decode", 1'b1);
      e.pc_we = 1'b0;
      cyc("cbz0_exec", e);

      // Unconditional branch.
      fetch_ack("b_fetch", OPC_B);
      decode("b_decode", 1'b0);
      e = mk(3'd3); e.aowe = 1'b1; e.pc_we = 1'b1; e.pc_src = 2'd2; e.ret = 1'b1;
      cyc("b_exec", e);

      // Illegal opcode halts; ack activity is ignored while halted.
      fetch_ack("ill_fetch", OPC_ILL);
      decode("ill_decode", 1'b0);
      e = mk(3'd7); e.halted = 1'b1;
      cyc("halt_1", e);
      mem_if.mem_ack = 1'b0;
      cyc("halt_2", e);
      mem_if.mem_ack = 1'b1;
      cyc("halt_3", e);
      release_reset("ill");

      // STUR timeout: sixteen waited MEM cycles, then HALT.
      fetch_ack("sto_fetch", OPC_STUR);
      decode("sto_decode", 1'b1);
      e = mk(3'd3); e.aowe = 1'b1; e.asrc = 1'b1; e.alu = 4'b0010;
      cyc("sto_exec", e);
      mem_if.mem_ack = 1'b0;
      e = mk(3'd4); e.req = 1'b1; e.we = 1'b1; e.asel = 1'b1;
      for (int i = 0; i < 16; i++) cyc("sto_mem_wait", e);
      e = mk(3'd7); e.halted = 1'b1;
      cyc("sto_halt", e);
      release_reset("sto");

      // Reset asserted mid-MEM drops mem_req; a late ack is ignored in RESET.
      fetch_ack("rm_fetch", OPC_STUR);
      decode("rm_decode", 1'b1);
      e = mk(3'd3); e.aowe = 1'b1; e.asrc = 1'b1; e.alu = 4'b0010;
      cyc("rm_exec", e);
      mem_if.mem_ack = 1'b0;
      e = mk(3'd4); e.req = 1'b1; e.we = 1'b1; e.asel = 1'b1;
      cyc("rm_mem_wait", e);
      RST = 1'b0;
      cyc("rm_mem_rst", e);
      mem_if.mem_ack = 1'b1;
      e = mk(3'd0);
      cyc("rm_reset_late_ack", e);
      RST = 1'b1;
      cyc("rm_reset_release", e);

      // Counter was cleared by reset: a fresh ADD still completes normally.
      rtype("add2", OPC_ADD, 4'b0010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
